// File: rtl/divisor_sequencial_8x4.sv
// Sequential restoring divider: LARG_DIVIDENDO-bit dividend / 4-bit divisor, one
// trial subtraction per clock on a shared 5x4 subtractor, start/done handshake.

module subtrator_5x4bits (
  input  logic [4:0] a,
  input  logic [3:0] b,
  input  logic       modo_sub,
  input  logic       cin_inicial,
  output logic [4:0] s,
  output logic       cout
);
  logic [4:0] b_ext;
  logic [5:0] soma;

  assign b_ext = modo_sub ? ~{1'b0, b} : {1'b0, b};
  assign soma  = {1'b0, a} + {1'b0, b_ext} + {5'd0, cin_inicial};
  assign s     = soma[4:0];
  assign cout  = soma[5];
endmodule

module divisor_sequencial_8x4 #(
  parameter int LARG_DIVIDENDO = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LARG_DIVIDENDO-1:0] dividendo,
  input  logic [3:0]                divisor,
  output logic                      busy,
  output logic                      done,
  output logic [LARG_DIVIDENDO-1:0] quociente,
  output logic [3:0]                resto,
  output logic                      erro_div0
);
  localparam int W  = LARG_DIVIDENDO;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

  estado_t         estado, estado_nxt;
  logic [W-1:0]    q_reg, q_nxt;
  logic [3:0]      r_reg, r_nxt, d_reg;
  logic [CW-1:0]   cnt;
  logic [4:0]      p, s;
  logic            cout, ge;

  // Shifted partial remainder against the captured divisor.
  assign p = {r_reg, q_reg[W-1]};

  subtrator_5x4bits u_sub (
    .a           (p),
    .b           (d_reg),
    .modo_sub    (1'b1),
    .cin_inicial (1'b1),
    .s           (s),
    .cout        (cout)
  );

  // s[4] is always 0 when cout=1 (P < 2*D), so folding it in changes nothing.
  assign ge    = cout & ~s[4];
  assign r_nxt = ge ? s[3:0] : p[3:0];
  assign q_nxt = {q_reg[W-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) estado <= OCIOSO;
    else     estado <= estado_nxt;
  end

  always_comb begin
    estado_nxt = estado;
    case (estado)
      OCIOSO:  if (start) estado_nxt = (divisor == 4'd0) ? FIM : CALCULA;
      CALCULA: if (cnt == '0) estado_nxt = FIM;
      FIM:     estado_nxt = OCIOSO;
      default: estado_nxt = OCIOSO;
    endcase
  end

  always_comb begin
    busy = (estado == CALCULA);
    done = (estado == FIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      quociente <= '0;
      resto     <= '0;
      erro_div0 <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: if (start) begin
          q_reg     <= dividendo;
          d_reg     <= divisor;
          r_reg     <= '0;
          cnt       <= CW'(W - 1);
          quociente <= (divisor == 4'd0) ? '1 : '0;
          resto     <= '0;
          erro_div0 <= (divisor == 4'd0);
        end
        CALCULA: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            quociente <= q_nxt;
            resto     <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor_sequencial_8x4.sv
// Scoreboarded bench for divisor_sequencial_8x4: driver pushes expected results
// from an arithmetic model, monitor pops and compares on every done pulse.

module tb_divisor_sequencial_8x4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividendo;
  logic [3:0]   divisor;
  logic         busy, done, erro_div0;
  logic [W-1:0] quociente;
  logic [3:0]   resto;

  typedef struct {
    logic [W-1:0] q;
    logic [3:0]   r;
    logic         e;
    logic [W-1:0] a;
    logic [3:0]   b;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   n_exp = 0, n_done = 0;

  divisor_sequencial_8x4 #(.LARG_DIVIDENDO(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quociente (quociente),
    .resto     (resto),
    .erro_div0 (erro_div0)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [3:0] b);
    exp_t x;
    x.a = a; x.b = b;
    if (b == 0) begin
      x.q = {W{1'b1}}; x.r = 4'd0; x.e = 1'b1;
    end else begin
      x.q = W'(int'(a) / int'(b));
      x.r = 4'(int'(a) % int'(b));
      x.e = 1'b0;
    end
    return x;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got q=%0d r=%0d e=%0d with nothing outstanding",
                 quociente, resto, erro_div0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (quociente !== x.q || resto !== x.r || erro_div0 !== x.e) begin
          bad++;
          $display("FAIL result %0d/%0d: got q=%0d r=%0d e=%0d expected q=%0d r=%0d e=%0d",
                   x.a, x.b, quociente, resto, erro_div0, x.q, x.r, x.e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check("idle_timeout", n, 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [3:0] b);
    int lat;
    bit saw_busy;
    wait_idle();
    start = 1'b1; dividendo = a; divisor = b;
    sb.push_back(model(a, b)); n_exp++;
    @(negedge clk);
    start = 1'b0;
    lat = 1; saw_busy = 1'b0;
    while (!done && lat < 40) begin
      saw_busy |= busy;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (b == 0) ? 1 : W + 1);
    if (b == 0) check("div0_busy", int'(saw_busy), 0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_q"}, int'(quociente), 0);
    check({name, "_r"}, int'(resto), 0);
    check({name, "_e"}, int'(erro_div0), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(8'd200, 4'd7);
    do_op(8'd255, 4'd15);
    do_op(8'd5, 4'd9);
    do_op(8'd0, 4'd1);
    do_op(8'hA5, 4'd0);
    do_op(8'd255, 4'd1);

    // start held high: only accepts at i=0 and i=10, mid-op operand noise ignored
    wait_idle();
    sb.push_back(model(8'd100, 4'd3)); n_exp++;
    sb.push_back(model(8'd100, 4'd3)); n_exp++;
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      if (i == 0 || i == 9 || i == 10 || i == 19) begin
        dividendo = 8'd100; divisor = 4'd3;
      end else begin
        dividendo = 8'($urandom); divisor = 4'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_outstanding", sb.size(), 0);

    // Reset during iteration 4 aborts without a done
    wait_idle();
    start = 1'b1; dividendo = 8'd200; divisor = 4'd7;
    sb.push_back(model(8'd200, 4'd7)); n_exp++;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete(); n_exp--;
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort");
    repeat (12) @(negedge clk);
    do_op(8'd13, 4'd2);

    // Random operands
    for (int i = 0; i < 200; i++) do_op(8'($urandom), 4'($urandom_range(0, 15)));

    // Exhaustive sweep
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) do_op(8'(a), 4'(b));

    repeat (4) @(negedge clk);
    check("done_count", n_done, n_exp);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
